rapcore_wb_spi_bridge: RTL and testbench



---
 rtl/rapcore_bridge_pkg.sv | 26 ++
 rtl/spi_frame_master.sv | 115 +++++++++++
 rtl/rapcore_wb_spi_bridge.sv | 172 +++++++++++++++++
 tb/tb_rapcore_wb_spi_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapcore_bridge_pkg.sv
// Shared constants for the rapcore Wishbone-to-SPI bridge: register map, CTRL bits, shifter states.
// Pure declarations; no timing or flow-control behaviour of its own.
package rapcore_bridge_pkg;

  localparam int FRAME_W = 32;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_RXVALID = 1;
  localparam int CTRL_TXDROP  = 2;
  localparam int CTRL_RXLOST  = 3;
  localparam int CTRL_CSHOLD  = 8;
  localparam int CTRL_IRQEN   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_e;

endpackage

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame shifter: one start pulse sends FRAME_W bits MSB first in 66*(div+1) cycles.
// No backpressure; start is only honoured while idle, done pulses on the last HOLD cycle.
module spi_frame_master
  import rapcore_bridge_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] tx_i,
  input  logic [15:0]        div_i,
  input  logic               cipo_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] rx_o,
  output logic               sck_o,
  output logic               copi_o
);

  spi_state_e         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
  logic               sck_q, sck_d;
  logic               half_end;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    sck_d    = sck_q;
    done_o   = 1'b0;
    half_end = (cnt_q == div_q);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          div_d   = div_i;
          bit_d   = '0;
          tx_sh_d = tx_i;
          sck_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (half_end) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_sh_d = {rx_sh_q[FRAME_W-2:0], cipo_i};
          end else begin
            // COPI advances on the falling edge; the frame ends after the last fall
            tx_sh_d = {tx_sh_q[FRAME_W-2:0], 1'b0};
            if (bit_q == 5'(FRAME_W - 1)) begin
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      sck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      sck_q   <= sck_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign rx_o   = rx_sh_q;
  assign sck_o  = sck_q;
  assign copi_o = tx_sh_q[FRAME_W-1];

endmodule

// File: rtl/rapcore_wb_spi_bridge.sv
// Wishbone register window driving rapcore's SPI command port; single-cycle registered ack.
// Never stalls the bus: DATA writes while busy are acked and dropped, flagged by tx_drop.
module rapcore_wb_spi_bridge
  import rapcore_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] DIV_RESET = 16'd7
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o,
  output logic        spi_copi_o,
  input  logic        spi_cipo_i,
  output logic        irq_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        start_q, start_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_drop_q, tx_drop_d;
  logic        rx_lost_q, rx_lost_d;
  logic        cs_hold_q, cs_hold_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] div_q, div_d;
  logic        irq_q, irq_d;

  logic        fm_busy, fm_done;
  logic [31:0] fm_rx;
  logic        hit, acc, rd_data, busy;
  logic [1:0]  off;
  logic [31:0] wmask, status;

  always_comb begin
    ack_d      = 1'b0;
    dat_d      = '0;
    start_d    = 1'b0;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_valid_d = rx_valid_q;
    tx_drop_d  = tx_drop_q;
    rx_lost_d  = rx_lost_q;
    cs_hold_d  = cs_hold_q;
    irq_en_d   = irq_en_q;
    div_d      = div_q;
    off        = wbs_adr_i[3:2];
    hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // ack_q blocks back-to-back acceptance so every ack is followed by a low cycle
    acc        = hit & ~ack_q;
    rd_data    = acc & ~wbs_we_i & (off == REG_DATA);
    // a start queued in start_q counts as busy before the shifter leaves idle
    busy       = fm_busy | start_q;
    wmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    status               = '0;
    status[CTRL_BUSY]    = busy;
    status[CTRL_RXVALID] = rx_valid_q;
    status[CTRL_TXDROP]  = tx_drop_q;
    status[CTRL_RXLOST]  = rx_lost_q;
    status[CTRL_CSHOLD]  = cs_hold_q;
    status[CTRL_IRQEN]   = irq_en_q;

    if (acc) begin
      ack_d = 1'b1;
      if (wbs_we_i) begin
        case (off)
          REG_DATA: begin
            if (|wbs_sel_i) begin
              if (busy) begin
                tx_drop_d = 1'b1;
              end else begin
                tx_d    = wbs_dat_i & wmask;
                start_d = 1'b1;
              end
            end
          end
          REG_CTRL: begin
            if (wbs_dat_i[CTRL_TXDROP]) tx_drop_d = 1'b0;
            if (wbs_dat_i[CTRL_RXLOST]) rx_lost_d = 1'b0;
            cs_hold_d = wbs_dat_i[CTRL_CSHOLD];
            irq_en_d  = wbs_dat_i[CTRL_IRQEN];
          end
          REG_DIV: begin
            if (wbs_sel_i[0]) div_d[7:0]  = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) div_d[15:8] = wbs_dat_i[15:8];
          end
          default: ;
        endcase
      end else begin
        case (off)
          REG_DATA: begin
            dat_d      = rx_q;
            rx_valid_d = 1'b0;
          end
          REG_CTRL: dat_d = status;
          REG_DIV:  dat_d = {16'd0, div_q};
          default:  dat_d = '0;
        endcase
      end
    end

    // completion overrides a same-cycle DATA read, which then does not count as a loss
    if (fm_done) begin
      rx_d       = fm_rx;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_data) rx_lost_d = 1'b1;
    end

    irq_d = rx_valid_q & irq_en_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      start_q    <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      tx_drop_q  <= 1'b0;
      rx_lost_q  <= 1'b0;
      cs_hold_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= DIV_RESET;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      tx_drop_q  <= tx_drop_d;
      rx_lost_q  <= rx_lost_d;
      cs_hold_q  <= cs_hold_d;
      irq_en_q   <= irq_en_d;
      div_q      <= div_d;
      irq_q      <= irq_d;
    end
  end

  spi_frame_master u_frame (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .start_i (start_q),
    .tx_i    (tx_q),
    .div_i   (div_q),
    .cipo_i  (spi_cipo_i),
    .busy_o  (fm_busy),
    .done_o  (fm_done),
    .rx_o    (fm_rx),
    .sck_o   (spi_sck_o),
    .copi_o  (spi_copi_o)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign spi_cs_o  = ~(fm_busy | cs_hold_q);
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_rapcore_wb_spi_bridge.sv
// Bench for rapcore_wb_spi_bridge: Wishbone master tasks, a behavioural SPI peripheral and register model.
module tb_rapcore_wb_spi_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        sck, cs, copi, cipo, irq;

  int checks = 0;
  int failures = 0;

  // register model
  logic [15:0] div_m;
  logic        cs_hold_m, irq_en_m;

  // peripheral model + monitor
  logic        loopback;
  logic [31:0] reply;
  logic        mon_clr;
  int          rises, cs_low_cnt, cs_high_cnt;
  logic [31:0] mosi;
  logic        sck_prev;

  always #5 clk = ~clk;

  rapcore_wb_spi_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .spi_sck_o  (sck),
    .spi_cs_o   (cs),
    .spi_copi_o (copi),
    .spi_cipo_i (cipo),
    .irq_o      (irq)
  );

  // mode-0 peripheral: presents reply MSB first, next bit after each SCK rise
  assign cipo = loopback ? copi : ((rises < 32) ? reply[5'd31 - rises[4:0]] : 1'b0);

  always @(negedge clk) begin
    if (mon_clr) begin
      rises       <= 0;
      mosi        <= '0;
      cs_low_cnt  <= 0;
      cs_high_cnt <= 0;
    end else begin
      if (sck && !sck_prev) begin
        rises <= rises + 1;
        mosi  <= {mosi[30:0], copi};
      end
      if (!cs) cs_low_cnt <= cs_low_cnt + 1;
      else     cs_high_cnt <= cs_high_cnt + 1;
    end
    sck_prev <= sck;
  end

  function automatic logic [31:0] exp_st(input logic b, input logic rv, input logic td, input logic rl);
    return {15'd0, irq_en_m, 7'd0, cs_hold_m, 4'd0, rl, td, rv, b};
  endfunction

  function automatic logic [31:0] sel_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    @(negedge clk);
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ack) begin
      checks++; failures++;
      $display("FAIL wb_ack_timeout adr=%h: no ack seen, ack required", a);
    end
    rd = rdat;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_cycle(1'b0, a, 32'h0, 4'hF, rd);
  endtask

  task automatic clr_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic wait_done();
    logic [31:0] st;
    int n;
    n = 0;
    do begin
      wb_read(BASE + 32'h4, st);
      n++;
    end while (st[0] && n < 400);
    if (st[0]) begin
      checks++; failures++;
      $display("FAIL frame_timeout busy=%0d, busy=0 required", st[0]);
    end
  endtask

  task automatic set_div(input logic [15:0] d);
    wb_write(BASE + 32'h8, {16'hDEAD, d}, 4'hF);
    div_m = d;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    loopback = 1'b1; reply = 0; mon_clr = 1'b1;
    div_m = 16'd7; cs_hold_m = 0; irq_en_m = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mon_clr = 1'b0;
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", cs); end
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck); end
    checks++; if (copi !== 1'b0) begin failures++; $display("FAIL reset_copi got=%b exp=0", copi); end
    checks++; if ({ack, irq} !== 2'b00) begin failures++; $display("FAIL reset_ack_irq got=%b exp=00", {ack, irq}); end
    checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", rdat); end
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", rd); end
    wb_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h7) begin failures++; $display("FAIL reset_clkdiv got=%h exp=7", rd); end
  endtask

  task automatic test_loopback();
    logic [31:0] rd;
    loopback = 1'b1;
    set_div(16'd0);
    clr_mon();
    wb_write(BASE, 32'hA5C3_0F01, 4'hF);
    wait_done();
    checks++; if (cs_low_cnt !== 66) begin failures++; $display("FAIL lb_cs_low got=%0d exp=66", cs_low_cnt); end
    checks++; if (rises !== 32) begin failures++; $display("FAIL lb_sck_pulses got=%0d exp=32", rises); end
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(0, 1, 0, 0)) begin failures++; $display("FAIL lb_status got=%h exp=%h", rd, exp_st(0, 1, 0, 0)); end
    wb_read(BASE, rd);
    checks++; if (rd !== 32'hA5C3_0F01) begin failures++; $display("FAIL lb_rx got=%h exp=a5c30f01", rd); end
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(0, 0, 0, 0)) begin failures++; $display("FAIL lb_rxv_clear got=%h exp=%h", rd, exp_st(0, 0, 0, 0)); end
  endtask

  task automatic test_random_frames();
    logic [31:0] rd, tx;
    logic [3:0]  s;
    int          d;
    loopback = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d     = $urandom_range(0, 3);
      s     = 4'($urandom_range(1, 15));
      tx    = $urandom;
      reply = $urandom;
      set_div(16'(d));
      clr_mon();
      wb_write(BASE, tx, s);
      wait_done();
      checks++; if (cs_low_cnt !== 66 * (d + 1)) begin failures++; $display("FAIL rnd_frame_len[%0d] got=%0d exp=%0d", i, cs_low_cnt, 66 * (d + 1)); end
      checks++; if (mosi !== (tx & sel_mask(s))) begin failures++; $display("FAIL rnd_copi[%0d] got=%h exp=%h", i, mosi, tx & sel_mask(s)); end
      wb_read(BASE, rd);
      checks++; if (rd !== reply) begin failures++; $display("FAIL rnd_rx[%0d] got=%h exp=%h", i, rd, reply); end
    end
    loopback = 1'b1;
  endtask

  task automatic test_tx_drop();
    logic [31:0] rd, t1, t2;
    t1 = $urandom; t2 = ~t1;
    set_div(16'd3);
    clr_mon();
    wb_write(BASE, t1, 4'hF);
    wb_write(BASE, t2, 4'hF);
    set_div(16'd0);
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(1, 0, 1, 0)) begin failures++; $display("FAIL drop_status got=%h exp=%h", rd, exp_st(1, 0, 1, 0)); end
    wait_done();
    checks++; if (cs_low_cnt !== 66 * 4) begin failures++; $display("FAIL drop_len_latched_div got=%0d exp=%0d", cs_low_cnt, 66 * 4); end
    checks++; if (mosi !== t1) begin failures++; $display("FAIL drop_copi got=%h exp=%h", mosi, t1); end
    wb_read(BASE, rd);
    checks++; if (rd !== t1) begin failures++; $display("FAIL drop_rx got=%h exp=%h", rd, t1); end
    wb_write(BASE + 32'h4, 32'h0000_0004, 4'hF);
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(0, 0, 0, 0)) begin failures++; $display("FAIL drop_w1c got=%h exp=%h", rd, exp_st(0, 0, 0, 0)); end
  endtask

  task automatic test_rx_lost_irq();
    logic [31:0] rd, ta, tb;
    ta = $urandom; tb = $urandom;
    irq_en_m = 1'b1;
    wb_write(BASE + 32'h4, 32'h0001_0000, 4'hF);
    wb_write(BASE, ta, 4'hF);
    wait_done();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    wb_write(BASE, tb, 4'hF);
    wait_done();
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(0, 1, 0, 1)) begin failures++; $display("FAIL lost_status got=%h exp=%h", rd, exp_st(0, 1, 0, 1)); end
    wb_read(BASE, rd);
    checks++; if (rd !== tb) begin failures++; $display("FAIL lost_rx got=%h exp=%h", rd, tb); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    wb_write(BASE + 32'h4, 32'h0001_0008, 4'hF);
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(0, 0, 0, 0)) begin failures++; $display("FAIL lost_w1c got=%h exp=%h", rd, exp_st(0, 0, 0, 0)); end
    irq_en_m = 1'b0;
    wb_write(BASE + 32'h4, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, t1, t2;
    t1 = $urandom; t2 = $urandom;
    cs_hold_m = 1'b1;
    wb_write(BASE + 32'h4, 32'h0000_0100, 4'hF);
    @(negedge clk);
    checks++; if (cs !== 1'b0) begin failures++; $display("FAIL hold_cs_idle got=%b exp=0", cs); end
    clr_mon();
    wb_write(BASE, t1, 4'hF);
    wait_done();
    wb_write(BASE, t2, 4'hF);
    wait_done();
    checks++; if (cs_high_cnt !== 0) begin failures++; $display("FAIL hold_cs_high_cycles got=%0d exp=0", cs_high_cnt); end
    checks++; if (rises !== 64 || mosi !== t2) begin failures++; $display("FAIL hold_frames got rises=%0d copi=%h exp rises=64 copi=%h", rises, mosi, t2); end
    wb_read(BASE, rd);
    checks++; if (rd !== t2) begin failures++; $display("FAIL hold_rx got=%h exp=%h", rd, t2); end
    cs_hold_m = 1'b0;
    wb_write(BASE + 32'h4, 32'h0000_0008, 4'hF);
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL hold_release_cs got=%b exp=1", cs); end
  endtask

  task automatic test_window();
    logic [31:0] rd, r;
    int acks;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
    acks = 0;
    repeat (8) begin @(negedge clk); if (ack) acks++; end
    checks++; if (acks !== 0) begin failures++; $display("FAIL window_no_ack got=%0d exp=0", acks); end
    adr = BASE + 32'hC;
    acks = 0;
    repeat (6) begin @(negedge clk); if (ack) acks++; end
    checks++; if (acks !== 3) begin failures++; $display("FAIL ack_pulse_count got=%0d exp=3", acks); end
    @(posedge clk); #1 cyc = 0; stb = 0;
    wb_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'hC, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rsvd_read got=%h exp=0", rd); end
    set_div(16'd0);
    wb_write(BASE + 32'h8, 32'hFFFF_FF12, 4'b0001);
    div_m[7:0] = 8'h12;
    wb_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_0012) begin failures++; $display("FAIL clkdiv_sel0 got=%h exp=00000012", rd); end
    r = $urandom;
    wb_write(BASE + 32'h8, r, 4'b1110);
    div_m[15:8] = r[15:8];
    wb_read(BASE + 32'h8, rd);
    checks++; if (rd !== {16'd0, div_m}) begin failures++; $display("FAIL clkdiv_sel1 got=%h exp=%h", rd, {16'd0, div_m}); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int n;
    set_div(16'd3);
    cs_hold_m = 1'b1;
    wb_write(BASE + 32'h4, 32'h0001_0100, 4'hF);
    clr_mon();
    wb_write(BASE, $urandom, 4'hF);
    n = 0;
    while (rises < 10 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (rises < 10) begin failures++; $display("FAIL midframe_reach_bit10 got=%0d exp=10", rises); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({cs, sck, copi, irq, ack} !== 5'b10000) begin failures++; $display("FAIL midframe_outputs got=%b exp=10000", {cs, sck, copi, irq, ack}); end
    rst = 1'b0;
    cs_hold_m = 0; irq_en_m = 0; div_m = 16'd7;
    wb_read(BASE + 32'h4, rd);
    checks++; if (rd !== exp_st(0, 0, 0, 0)) begin failures++; $display("FAIL midframe_status got=%h exp=%h", rd, exp_st(0, 0, 0, 0)); end
    wb_read(BASE + 32'h8, rd);
    checks++; if (rd !== {16'd0, div_m}) begin failures++; $display("FAIL midframe_clkdiv got=%h exp=%h", rd, {16'd0, div_m}); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_random_frames();
    test_tx_drop();
    test_rx_lost_irq();
    test_back_to_back();
    test_window();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
